// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bus between the VGA timing master and the graphics generators,
// plus the registered VGA pin signals.
interface vga_sync_gen_if;
  logic        p_tick;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        video_on;
  logic        frame_tick;
  logic [11:0] rgb_in;
  logic        test_mode;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_out;

  modport master (
    output p_tick, pix_x, pix_y, video_on, frame_tick, hsync, vsync, rgb_out,
    input  rgb_in, test_mode
  );

  modport slave (
    input  p_tick, pix_x, pix_y, video_on, frame_tick, hsync, vsync, rgb_out,
    output rgb_in, test_mode
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-tick divider, h/v counters, frame tick, blanked colour
// and sync pin registers. VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  vga_sync_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0] Y_DISP   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] Y_FT     = 10'(V_DISPLAY);

  logic [DIV_W-1:0] r_div;
  logic             r_p_tick;
  logic [9:0]       r_pix_x;
  logic [9:0]       r_pix_y;
  logic             r_frame_tick;
  logic             r_hsync;
  logic             r_vsync;
  logic [11:0]      r_rgb;

  logic             w_video_on;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_hs_win;
  logic             w_vs_win;
  logic [11:0]      w_colour;

  assign w_video_on = (r_pix_x < X_DISP) && (r_pix_y < Y_DISP);
  assign w_x_last   = (r_pix_x == X_LAST);
  assign w_y_last   = (r_pix_y == Y_LAST);
  assign w_hs_win   = (r_pix_x >= HS_FIRST) && (r_pix_x <= HS_LAST);
  assign w_vs_win   = (r_pix_y >= VS_FIRST) && (r_pix_y <= VS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_p_tick <= 1'b0;
    end else begin
      r_p_tick <= (r_div == DIV_LAST);
      r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      // Pulse lands on the same edge that moves the counters to (0, V_DISPLAY+1).
      r_frame_tick <= r_p_tick && w_x_last && (r_pix_y == Y_FT);
      if (r_p_tick) begin
        if (w_x_last) begin
          r_pix_x <= '0;
          r_pix_y <= w_y_last ? '0 : r_pix_y + 10'd1;
        end else begin
          r_pix_x <= r_pix_x + 10'd1;
        end
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  w_bar;
  logic [11:0] w_bar_colour;

  always_comb begin
    w_bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (r_pix_x >= 10'(80 * i)) w_bar = 3'(i);
    end
  end

  always_comb begin
    w_bar_colour = '0;
    case (w_bar)
      3'd0: w_bar_colour = 12'hfff;
      3'd1: w_bar_colour = 12'hff0;
      3'd2: w_bar_colour = 12'h0ff;
      3'd3: w_bar_colour = 12'h0f0;
      3'd4: w_bar_colour = 12'hf0f;
      3'd5: w_bar_colour = 12'hf00;
      3'd6: w_bar_colour = 12'h00f;
      default: w_bar_colour = 12'h000;
    endcase
  end

  assign w_colour = vga.test_mode ? w_bar_colour : vga.rgb_in;
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = vga.test_mode;
  assign w_colour           = vga.rgb_in;
`endif

  // Colour and both syncs sample the same pixel, so the pins lag pix_x/pix_y by one pixel together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb   <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else if (r_p_tick) begin
      r_rgb   <= w_video_on ? w_colour : '0;
      r_hsync <= w_hs_win ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs_win ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.p_tick     = r_p_tick;
  assign vga.pix_x      = r_pix_x;
  assign vga.pix_y      = r_pix_y;
  assign vga.video_on   = w_video_on;
  assign vga.frame_tick = r_frame_tick;
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.rgb_out    = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shortened frame (656 x 5, CLK_DIV 4).
module tb_vga_sync_gen;
  localparam int unsigned HD  = 640;
  localparam int unsigned HF  = 4;
  localparam int unsigned HS  = 6;
  localparam int unsigned HB  = 6;
  localparam int unsigned VD  = 2;
  localparam int unsigned VF  = 1;
  localparam int unsigned VS  = 1;
  localparam int unsigned VB  = 1;
  localparam int unsigned DIV = 4;
  localparam int unsigned HT  = HD + HF + HS + HB;
  localparam int unsigned VT  = VD + VF + VS + VB;
  localparam int unsigned FRAME_CLKS = HT * VT * DIV;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } pins_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vga_sync_gen_if vga();

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vga(vga)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pins_t       sb_q[$];
  int unsigned m_x = 0, m_y = 0;
  bit          ft_exp = 1'b0, ft_valid = 1'b0;
  int unsigned ft_last = 0, ft_count = 0;
  bit          use_const = 1'b0;
  logic [11:0] const_col = 12'h000;
  pins_t       last_pins;

  function automatic pins_t model_pins(int unsigned x, int unsigned y, logic [11:0] col);
    pins_t p;
    p.rgb = (x < HD && y < VD) ? col : 12'h000;
    p.hs  = (x >= HD + HF && x < HD + HF + HS) ? 1'b0 : 1'b1;
    p.vs  = (y >= VD + VF && y < VD + VF + VS) ? 1'b0 : 1'b1;
    return p;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] bar_colour(int unsigned x);
    case (x / 80)
      0: return 12'hfff;
      1: return 12'hff0;
      2: return 12'h0ff;
      3: return 12'h0f0;
      4: return 12'hf0f;
      5: return 12'hf00;
      6: return 12'h00f;
      default: return 12'h000;
    endcase
  endfunction
`endif

  function automatic logic [35:0] reset_snapshot();
    return {vga.rgb_out, vga.hsync, vga.vsync, vga.pix_x, vga.pix_y, vga.p_tick, vga.frame_tick};
  endfunction

  localparam logic [35:0] RESET_STATE = {12'h000, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0};

  // One pixel: wait for p_tick, check counters, push expected pins, check them after the edge.
  task automatic step_pixel();
    int unsigned gap = 0;
    bit          got = 1'b0;
    logic [11:0] drv, col;
    pins_t       exp_p, got_p;
    while (!got && gap < 4 * DIV) begin
      @(negedge clk);
      gap++;
      n_cmp++;
      if (vga.frame_tick !== ft_exp) begin
        n_err++;
        $display("FAIL frame_tick: got %b want %b at model x=%0d y=%0d", vga.frame_tick, ft_exp, m_x, m_y);
      end
      if (vga.frame_tick === 1'b1) begin
        n_cmp++;
        if (vga.pix_x !== 10'd0 || vga.pix_y !== 10'(VD + 1)) begin
          n_err++;
          $display("FAIL frame_tick_pos: got x=%0d y=%0d want x=0 y=%0d", vga.pix_x, vga.pix_y, VD + 1);
        end
        if (ft_valid) begin
          n_cmp++;
          if (cyc - ft_last != FRAME_CLKS) begin
            n_err++;
            $display("FAIL frame_period: got %0d clks want %0d", cyc - ft_last, FRAME_CLKS);
          end
        end
        ft_valid = 1'b1;
        ft_last  = cyc;
        ft_count++;
      end
      ft_exp = 1'b0;
      if (vga.p_tick === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL p_tick_timeout: no p_tick within %0d clks, want one every %0d", gap, DIV);
      return;
    end
    n_cmp++;
    if (gap != DIV) begin
      n_err++;
      $display("FAIL p_tick_period: got %0d clks want %0d", gap, DIV);
    end
    n_cmp++;
    if (vga.pix_x !== 10'(m_x) || vga.pix_y !== 10'(m_y)) begin
      n_err++;
      $display("FAIL counters: got x=%0d y=%0d want x=%0d y=%0d", vga.pix_x, vga.pix_y, m_x, m_y);
    end
    n_cmp++;
    if (vga.video_on !== (m_x < HD && m_y < VD)) begin
      n_err++;
      $display("FAIL video_on: got %b want %b at x=%0d y=%0d", vga.video_on, (m_x < HD && m_y < VD), m_x, m_y);
    end
    drv = use_const ? const_col : 12'($urandom);
    vga.rgb_in = drv;
    col = drv;
`ifdef VGA_TEST_PATTERN_EN
    if (vga.test_mode) col = bar_colour(m_x);
`endif
    sb_q.push_back(model_pins(m_x, m_y, col));
    @(posedge clk);
    #1;
    got_p.rgb = vga.rgb_out;
    got_p.hs  = vga.hsync;
    got_p.vs  = vga.vsync;
    exp_p = sb_q.pop_front();
    n_cmp++;
    if (got_p !== exp_p) begin
      n_err++;
      $display("FAIL pins x=%0d y=%0d: got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
               m_x, m_y, got_p.rgb, got_p.hs, got_p.vs, exp_p.rgb, exp_p.hs, exp_p.vs);
    end
    last_pins = got_p;
    if (m_x == HT - 1) begin
      m_x = 0;
      m_y = (m_y == VT - 1) ? 0 : m_y + 1;
    end else begin
      m_x++;
    end
    ft_exp = (m_x == 0 && m_y == VD + 1);
    vga.rgb_in = 12'($urandom);
  endtask

  task automatic run_until(int unsigned x, int unsigned y);
    int unsigned guard = 0;
    while (!(m_x == x && m_y == y) && guard < HT * VT + 2) begin
      step_pixel();
      guard++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vga.rgb_in = 12'hfff;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (reset_snapshot() !== RESET_STATE) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", reset_snapshot(), RESET_STATE);
    end
    m_x = 0; m_y = 0; ft_exp = 1'b0; ft_valid = 1'b0;
    reset_n = 1'b1;
    step_pixel();
    n_cmp++;
    if (vga.pix_x !== 10'd1 || vga.pix_y !== 10'd0) begin
      n_err++;
      $display("FAIL first_pixel: got x=%0d y=%0d want x=1 y=0", vga.pix_x, vga.pix_y);
    end
    repeat (4) step_pixel();
  endtask

  task automatic test_line_wrap();
    run_until(HT - 1, 1);
    step_pixel();
    n_cmp++;
    if (vga.pix_x !== 10'd0 || vga.pix_y !== 10'd2) begin
      n_err++;
      $display("FAIL line_wrap: got x=%0d y=%0d want x=0 y=2", vga.pix_x, vga.pix_y);
    end
    run_until(HT - 1, VT - 1);
    step_pixel();
    n_cmp++;
    if (vga.pix_x !== 10'd0 || vga.pix_y !== 10'd0) begin
      n_err++;
      $display("FAIL frame_wrap: got x=%0d y=%0d want x=0 y=0", vga.pix_x, vga.pix_y);
    end
  endtask

  task automatic test_hsync();
    int unsigned low_cnt = 0, n_falls = 0;
    int unsigned falls[2] = '{0, 0};
    logic prev = 1'b1;
    if (m_x != 0) run_until(0, (m_y + 1) % VT);
    for (int unsigned s = 0; s < 2 * HT; s++) begin
      step_pixel();
      if (last_pins.hs === 1'b0) begin
        low_cnt++;
        if (prev === 1'b1) begin
          if (n_falls < 2) falls[n_falls] = s;
          n_falls++;
        end
      end
      prev = last_pins.hs;
    end
    n_cmp++;
    if (low_cnt != 2 * HS || n_falls != 2) begin
      n_err++;
      $display("FAIL hsync_width: got %0d low pixels in %0d pulses want %0d in 2", low_cnt, n_falls, 2 * HS);
    end
    n_cmp++;
    if (falls[0] != HD + HF || falls[1] - falls[0] != HT) begin
      n_err++;
      $display("FAIL hsync_place: got start=%0d period=%0d want start=%0d period=%0d",
               falls[0], falls[1] - falls[0], HD + HF, HT);
    end
  endtask

  task automatic test_vsync();
    int unsigned low_cnt = 0, n_falls = 0, fx = 0, fy = 0;
    int unsigned px, py;
    logic prev = last_pins.vs;
    for (int unsigned s = 0; s < HT * VT; s++) begin
      px = m_x;
      py = m_y;
      step_pixel();
      if (last_pins.vs === 1'b0) begin
        low_cnt++;
        if (prev === 1'b1) begin
          n_falls++;
          fx = px;
          fy = py;
        end
      end
      prev = last_pins.vs;
    end
    n_cmp++;
    if (low_cnt != VS * HT || n_falls != 1) begin
      n_err++;
      $display("FAIL vsync_width: got %0d low pixels in %0d pulses want %0d in 1", low_cnt, n_falls, VS * HT);
    end
    n_cmp++;
    if (fx != 0 || fy != VD + VF) begin
      n_err++;
      $display("FAIL vsync_place: got start x=%0d y=%0d want x=0 y=%0d", fx, fy, VD + VF);
    end
  endtask

  task automatic test_blanking();
    int unsigned n_on = 0, n_off = 0;
    use_const = 1'b1;
    const_col = 12'hfff;
    for (int unsigned s = 0; s < HT * VT; s++) begin
      step_pixel();
      if (last_pins.rgb === 12'hfff) n_on++;
      if (last_pins.rgb === 12'h000) n_off++;
    end
    use_const = 1'b0;
    n_cmp++;
    if (n_on != HD * VD || n_off != HT * VT - HD * VD) begin
      n_err++;
      $display("FAIL blanking: got %0d lit / %0d dark want %0d / %0d", n_on, n_off, HD * VD, HT * VT - HD * VD);
    end
  endtask

  task automatic test_frame_tick();
    int unsigned c0 = ft_count;
    repeat (HT * VT) step_pixel();
    n_cmp++;
    if (ft_count - c0 != 1) begin
      n_err++;
      $display("FAIL frame_tick_count: got %0d pulses in one frame want 1", ft_count - c0);
    end
  endtask

  task automatic test_pattern();
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] want [3] = '{12'hff0, 12'h00f, 12'h000};
    int unsigned xs   [3] = '{85, 500, 600};
    vga.test_mode = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      run_until(xs[i], 1);
      step_pixel();
      n_cmp++;
      if (last_pins.rgb !== want[i]) begin
        n_err++;
        $display("FAIL test_pattern x=%0d: got %h want %h", xs[i], last_pins.rgb, want[i]);
      end
    end
    vga.test_mode = 1'b0;
`endif
  endtask

  task automatic test_mid_frame_reset();
    use_const = 1'b1;
    const_col = 12'h5a5;
    run_until(300, 1);
    use_const = 1'b0;
    n_cmp++;
    if (vga.rgb_out !== 12'h5a5) begin
      n_err++;
      $display("FAIL pre_reset_rgb: got %h want 5a5", vga.rgb_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (reset_snapshot() !== RESET_STATE) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", reset_snapshot(), RESET_STATE);
    end
    m_x = 0; m_y = 0; ft_exp = 1'b0; ft_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step_pixel();
    n_cmp++;
    if (vga.pix_x !== 10'd1 || vga.pix_y !== 10'd0) begin
      n_err++;
      $display("FAIL restart: got x=%0d y=%0d want x=1 y=0", vga.pix_x, vga.pix_y);
    end
    repeat (4) step_pixel();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    vga.rgb_in = 12'h000;
    vga.test_mode = 1'b0;
    test_reset();
    test_line_wrap();
    test_hsync();
    test_vsync();
    test_blanking();
    test_frame_tick();
    test_pattern();
    test_mid_frame_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
